// File: rtl/onchip_memory_arbiter.sv
// Two-master round-robin arbiter in front of a single-port on-chip memory.
// One command per cycle; read returns are steered back to the issuing
// master after a fixed memory read latency.
module onchip_memory_arbiter #(
  parameter int          ADDR_W       = 14,
  parameter int          DATA_W       = 32,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                freeze,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
);

  logic                    w_req0;
  logic                    w_req1;
  logic                    w_gnt0;
  logic                    w_gnt1;
  logic                    w_rd_accept;
  logic                    w_ret_vld;
  // 0 = m0 was granted last, 1 = m1 was granted last
  logic                    r_last_grant;
  // read-return pipeline: valid flag and owning master per stage
  logic [READ_LATENCY-1:0] r_vld;
  logic [READ_LATENCY-1:0] r_own;

  assign w_req0 = m0_read | m0_write;
  assign w_req1 = m1_read | m1_write;

  // Round-robin grant: lone requester wins, contention goes to the master not served last
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!reset && !freeze) begin
      if (w_req0 && (!w_req1 || r_last_grant)) begin
        w_gnt0 = 1'b1;
      end else if (w_req1) begin
        w_gnt1 = 1'b1;
      end
    end
  end

  assign m0_waitrequest = w_req0 & ~w_gnt0;
  assign m1_waitrequest = w_req1 & ~w_gnt1;

  // Memory command mux; everything idles at zero when nobody is granted
  always_comb begin
    mem_address    = '0;
    mem_byteenable = '0;
    mem_writedata  = '0;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    w_rd_accept    = 1'b0;
    if (w_gnt0) begin
      mem_address    = m0_address;
      mem_byteenable = m0_byteenable;
      mem_writedata  = m0_writedata;
      mem_chipselect = 1'b1;
      mem_write      = m0_write;
      w_rd_accept    = m0_read & ~m0_write;
    end else if (w_gnt1) begin
      mem_address    = m1_address;
      mem_byteenable = m1_byteenable;
      mem_writedata  = m1_writedata;
      mem_chipselect = 1'b1;
      mem_write      = m1_write;
      w_rd_accept    = m1_read & ~m1_write;
    end
  end

  assign mem_clken = ~reset;

  // Remember which master was served on the most recent granted cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant <= 1'b1;
    end else if (w_gnt0 || w_gnt1) begin
      r_last_grant <= w_gnt1;
    end
  end

  // Shift accepted reads along with the memory's fixed read latency
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld <= '0;
      r_own <= '0;
    end else begin
      r_vld[0] <= w_rd_accept;
      r_own[0] <= w_gnt1;
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_own[i] <= r_own[i-1];
      end
    end
  end

  // Returns are suppressed while reset is held so in-flight reads never surface
  assign w_ret_vld        = r_vld[READ_LATENCY-1] & ~reset;
  assign m0_readdatavalid = w_ret_vld & ~r_own[READ_LATENCY-1];
  assign m1_readdatavalid = w_ret_vld &  r_own[READ_LATENCY-1];
  assign m0_readdata      = w_ret_vld ? mem_readdata : '0;
  assign m1_readdata      = w_ret_vld ? mem_readdata : '0;

endmodule

// File: tb/tb_onchip_memory_arbiter.sv
// Bench for onchip_memory_arbiter: memory model on the mem_* side, a
// transaction-level reference model, a vector table, directed corner
// sequences and a randomized phase.
module tb_onchip_memory_arbiter;
  localparam int AW = 14;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int L  = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, freeze;
  logic [AW-1:0] m0_address, m1_address, mem_address;
  logic [BW-1:0] m0_byteenable, m1_byteenable, mem_byteenable;
  logic          m0_read, m0_write, m1_read, m1_write;
  logic [DW-1:0] m0_writedata, m1_writedata, mem_writedata, mem_readdata;
  logic          m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic [DW-1:0] m0_readdata, m1_readdata;
  logic          mem_chipselect, mem_write, mem_clken;

  onchip_memory_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(L)) dut (
    .clk(clk), .reset(reset), .freeze(freeze),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
  );

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                          input logic [BW-1:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < BW; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Memory: registered read with L cycles of latency, byte-lane writes
  logic [DW-1:0] mem [0:16383];
  logic [DW-1:0] rd_pipe [0:L-1];
  assign mem_readdata = rd_pipe[L-1];
  always @(posedge clk) begin
    if (mem_clken) begin
      rd_pipe[0] <= mem[mem_address];
      for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
      if (mem_chipselect && mem_write)
        mem[mem_address] <= merge(mem[mem_address], mem_writedata, mem_byteenable);
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: transactions, round-robin by rule, sparse memory contents
  typedef struct { int due; int owner; bit known; logic [DW-1:0] data; } ret_t;
  ret_t          ret_q[$];
  int            last_g = 1;
  logic [DW-1:0] ref_mem [int];

  task automatic model_check();
    bit rq0, rq1, rd, wr, erv0, erv1;
    int g;
    int a;
    logic [AW-1:0] ea;
    logic [BW-1:0] eb;
    logic [DW-1:0] ed;
    ret_t r;
    rq0 = m0_read || m0_write;
    rq1 = m1_read || m1_write;
    g = -1;
    if (!reset && !freeze) begin
      if (rq0 && rq1) g = 1 - last_g;
      else if (rq0)   g = 0;
      else if (rq1)   g = 1;
    end
    ea = '0; eb = '0; ed = '0; rd = 0; wr = 0;
    if (g == 0) begin ea = m0_address; eb = m0_byteenable; ed = m0_writedata; wr = m0_write; rd = m0_read && !m0_write; end
    if (g == 1) begin ea = m1_address; eb = m1_byteenable; ed = m1_writedata; wr = m1_write; rd = m1_read && !m1_write; end
    chk1("m0_waitrequest", m0_waitrequest, rq0 && g != 0);
    chk1("m1_waitrequest", m1_waitrequest, rq1 && g != 1);
    chk1("mem_chipselect", mem_chipselect, g >= 0);
    chk1("mem_write", mem_write, wr);
    chk32("mem_address", 32'(mem_address), 32'(ea));
    chk32("mem_byteenable", 32'(mem_byteenable), 32'(eb));
    chk32("mem_writedata", mem_writedata, ed);
    chk1("mem_clken", mem_clken, !reset);
    erv0 = 0; erv1 = 0;
    if (!reset && ret_q.size() > 0 && ret_q[0].due == cyc) begin
      r = ret_q.pop_front();
      if (r.owner == 0) erv0 = 1; else erv1 = 1;
      if (r.known && r.owner == 0) chk32("m0_readdata", m0_readdata, r.data);
      if (r.known && r.owner == 1) chk32("m1_readdata", m1_readdata, r.data);
    end
    chk1("m0_readdatavalid", m0_readdatavalid, erv0);
    chk1("m1_readdatavalid", m1_readdatavalid, erv1);
    if (reset) begin
      chk32("m0_readdata_rst", m0_readdata, '0);
      chk32("m1_readdata_rst", m1_readdata, '0);
      ret_q.delete();
      last_g = 1;
    end else if (g >= 0) begin
      last_g = g;
      a = int'(ea);
      if (wr) begin
        if (ref_mem.exists(a)) ref_mem[a] = merge(ref_mem[a], ed, eb);
        else if (eb == 4'hF) ref_mem[a] = ed;
      end else if (rd) begin
        r.due = cyc + L; r.owner = g; r.known = ref_mem.exists(a);
        r.data = r.known ? ref_mem[a] : '0;
        ret_q.push_back(r);
      end
    end
  endtask

  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic finish_cycle();
    model_check();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle();
    m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
    m0_address = '0; m1_address = '0; m0_byteenable = '0; m1_byteenable = '0;
    m0_writedata = '0; m1_writedata = '0;
  endtask

  task automatic set_m(input int m, input bit rd, input bit wr, input logic [AW-1:0] a,
                       input logic [BW-1:0] be, input logic [DW-1:0] d);
    if (m == 0) begin
      m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = d;
    end else begin
      m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = d;
    end
  endtask

  task automatic cycle();
    to_neg();
    finish_cycle();
  endtask

  typedef struct {
    bit rst, frz, r0, w0, r1, w1;
    bit ew0, ew1, ecs, ewr, erv0, erv1;
  } vec_t;
  vec_t tv [13];

  initial begin
    tv[0]  = '{1,0,1,0,1,0, 1,1,0,0,0,0};
    tv[1]  = '{0,0,1,0,1,0, 0,1,1,0,0,0};
    tv[2]  = '{0,0,1,0,1,0, 1,0,1,0,1,0};
    tv[3]  = '{0,0,1,0,1,0, 0,1,1,0,0,1};
    tv[4]  = '{0,0,0,0,1,0, 0,0,1,0,1,0};
    tv[5]  = '{0,0,1,0,1,0, 0,1,1,0,0,1};
    tv[6]  = '{0,1,1,0,1,0, 1,1,0,0,1,0};
    tv[7]  = '{0,0,1,0,1,0, 1,0,1,0,0,0};
    tv[8]  = '{0,0,0,1,0,0, 0,0,1,1,0,1};
    tv[9]  = '{0,0,0,0,0,0, 0,0,0,0,0,0};
    tv[10] = '{0,0,1,1,1,0, 1,0,1,0,0,0};
    tv[11] = '{0,0,1,1,0,0, 0,0,1,1,0,1};
    tv[12] = '{0,0,0,0,0,0, 0,0,0,0,0,0};

    reset = 1; freeze = 0; idle();
    repeat (2) cycle();

    // Vector table: fairness, freeze, illegal read+write, with hand-derived outputs
    for (int i = 0; i < 13; i++) begin
      reset = tv[i].rst; freeze = tv[i].frz;
      set_m(0, tv[i].r0, tv[i].w0, 14'(16'h0100 + i), 4'hF, 32'hC0DE_0000 + i);
      set_m(1, tv[i].r1, tv[i].w1, 14'(16'h0200 + i), 4'hF, 32'hBEEF_0000 + i);
      to_neg();
      chk1("tv_wait0", m0_waitrequest, tv[i].ew0);
      chk1("tv_wait1", m1_waitrequest, tv[i].ew1);
      chk1("tv_cs", mem_chipselect, tv[i].ecs);
      chk1("tv_wr", mem_write, tv[i].ewr);
      chk1("tv_rv0", m0_readdatavalid, tv[i].erv0);
      chk1("tv_rv1", m1_readdatavalid, tv[i].erv1);
      finish_cycle();
    end
    reset = 0; freeze = 0; idle();

    // Single read after full write
    set_m(0, 0, 1, 14'h0010, 4'hF, 32'hDEADBEEF);
    to_neg(); chk1("sr_wait_wr", m0_waitrequest, 1'b0); finish_cycle();
    idle(); set_m(0, 1, 0, 14'h0010, 4'hF, '0);
    to_neg(); chk1("sr_wait_rd", m0_waitrequest, 1'b0); finish_cycle();
    idle();
    repeat (L-1) cycle();
    to_neg();
    chk1("sr_rv0", m0_readdatavalid, 1'b1);
    chk32("sr_data", m0_readdata, 32'hDEADBEEF);
    chk1("sr_rv1", m1_readdatavalid, 1'b0);
    finish_cycle();

    // Byte-lane write at the top address
    set_m(1, 0, 1, 14'h3FFF, 4'hF, 32'hAAAAAAAA); cycle();
    set_m(1, 0, 1, 14'h3FFF, 4'h3, 32'h11223344); cycle();
    set_m(1, 1, 0, 14'h3FFF, 4'hF, '0); cycle();
    idle();
    repeat (L-1) cycle();
    to_neg();
    chk1("bl_rv1", m1_readdatavalid, 1'b1);
    chk32("bl_data", m1_readdata, 32'hAAAA3344);
    chk1("bl_rv0", m0_readdatavalid, 1'b0);
    finish_cycle();

    // Freeze with a read in flight and m1 waiting
    set_m(0, 1, 0, 14'h0010, 4'hF, '0); set_m(1, 1, 0, 14'h0300, 4'hF, '0);
    to_neg(); chk1("fz_gnt0", m0_waitrequest, 1'b0); finish_cycle();
    freeze = 1;
    repeat (L-1) cycle();
    to_neg();
    chk1("fz_rv0", m0_readdatavalid, 1'b1);
    chk32("fz_data", m0_readdata, 32'hDEADBEEF);
    chk1("fz_wait1a", m1_waitrequest, 1'b1);
    finish_cycle();
    to_neg(); chk1("fz_wait1b", m1_waitrequest, 1'b1); finish_cycle();
    freeze = 0;
    to_neg();
    chk1("fz_gnt1", m1_waitrequest, 1'b0);
    chk1("fz_wait0", m0_waitrequest, 1'b1);
    finish_cycle();
    idle();

    // Reset while an m1 read is outstanding
    set_m(1, 1, 0, 14'h3FFF, 4'hF, '0);
    to_neg(); chk1("rs_acc", m1_waitrequest, 1'b0); finish_cycle();
    idle(); reset = 1;
    to_neg(); chk1("rs_rv1_rst", m1_readdatavalid, 1'b0); finish_cycle();
    reset = 0;
    for (int k = 0; k <= L; k++) begin
      to_neg(); chk1("rs_rv1_after", m1_readdatavalid, 1'b0); finish_cycle();
    end
    set_m(0, 1, 0, 14'h0001, 4'hF, '0); set_m(1, 1, 0, 14'h0002, 4'hF, '0);
    to_neg();
    chk1("rs_gnt0", m0_waitrequest, 1'b0);
    chk1("rs_wait1", m1_waitrequest, 1'b1);
    finish_cycle();
    idle();

    // Illegal read+write on m0: write happens, no return
    set_m(0, 1, 1, 14'h0020, 4'hF, 32'h12345678); cycle();
    idle();
    for (int k = 0; k <= L; k++) begin
      to_neg(); chk1("il_norv", m0_readdatavalid, 1'b0); finish_cycle();
    end
    set_m(0, 1, 0, 14'h0020, 4'hF, '0); cycle();
    idle();
    repeat (L-1) cycle();
    to_neg();
    chk1("il_rv0", m0_readdatavalid, 1'b1);
    chk32("il_data", m0_readdata, 32'h12345678);
    finish_cycle();

    // Randomized traffic against the reference model
    for (int n = 0; n < 800; n++) begin
      reset  = ($urandom_range(0, 49) == 0);
      freeze = ($urandom_range(0, 9) == 0);
      for (int m = 0; m < 2; m++) begin
        int  op;
        bit  rd, wr;
        op = int'($urandom_range(0, 19));
        rd = (op >= 6 && op < 13) || op == 19;
        wr = (op >= 13);
        set_m(m, rd, wr, 14'(14'h0040 + $urandom_range(0, 15)),
              ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15)), $urandom);
      end
      cycle();
    end
    reset = 0; freeze = 0; idle();
    repeat (L + 1) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
